// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb per instruction.
// Optional OVERFLOW_TRAP_EN: registers alu Overflow for add/sub/addi and suppresses the write.
module multicycle_ctrl #(
    parameter int ST_W    = 3,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               Overflow,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               EXTOp,
    output logic [1:0]         NPCOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal,
    output logic               ovf_trap,
    output logic [ST_W-1:0]    state
);

    localparam logic [ALUOP_W-1:0] ALU_NOP  = 0;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 1;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 2;
    localparam logic [ALUOP_W-1:0] ALU_ADDU = 3;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4;
    localparam logic [ALUOP_W-1:0] ALU_SUBU = 5;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 6;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 7;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 8;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 9;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 10;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 11;

    typedef enum logic [ST_W-1:0] {
        FETCH  = 0,
        DECODE = 1,
        EXEC   = 2,
        MEM    = 3,
        WB     = 4,
        BRANCH = 5,
        JUMP   = 6,
        SPARE  = 7
    } st_t;

    st_t st, nxt;

    logic is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic is_zext, ovf_cand, ovf_q;
    logic [ALUOP_W-1:0] r_op, i_op;

    always_comb begin
        is_r = 1'b0;
        r_op = ALU_NOP;
        if (Op == 6'h00) begin
            is_r = 1'b1;
            case (Funct)
                6'h20: r_op = ALU_ADD;
                6'h21: r_op = ALU_ADDU;
                6'h22: r_op = ALU_SUB;
                6'h23: r_op = ALU_SUBU;
                6'h24: r_op = ALU_AND;
                6'h25: r_op = ALU_OR;
                6'h26: r_op = ALU_XOR;
                6'h27: r_op = ALU_NOR;
                6'h2A: r_op = ALU_SLT;
                6'h2B: r_op = ALU_SLTU;
                default: is_r = 1'b0;
            endcase
        end
    end

    always_comb begin
        is_i    = 1'b0;
        is_zext = 1'b0;
        i_op    = ALU_ADDU;
        case (Op)
            6'h08: begin is_i = 1'b1; i_op = ALU_ADD; end
            6'h09: begin is_i = 1'b1; i_op = ALU_ADDU; end
            6'h0C: begin is_i = 1'b1; is_zext = 1'b1; i_op = ALU_AND; end
            6'h0D: begin is_i = 1'b1; is_zext = 1'b1; i_op = ALU_OR; end
            6'h0F: begin is_i = 1'b1; is_zext = 1'b1; i_op = ALU_LUI; end
            default: ;
        endcase
    end

    assign is_lw  = (Op == 6'h23);
    assign is_sw  = (Op == 6'h2B);
    assign is_beq = (Op == 6'h04);
    assign is_bne = (Op == 6'h05);
    assign is_j   = (Op == 6'h02);
    assign is_jal = (Op == 6'h03);

    // Only signed adds/subtracts can trap
    assign ovf_cand = (is_r && (Funct == 6'h20 || Funct == 6'h22))
                    || (Op == 6'h08);

    always_comb begin
        nxt      = st;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        WDSel    = 2'd0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        EXTOp    = 1'b0;
        NPCOp    = 2'd0;
        ALUOp    = ALU_NOP;
        illegal  = 1'b0;
        ovf_trap = 1'b0;
        case (st)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                ALUOp   = ALU_ADDU;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADDU;
                if (is_r || is_i || is_lw || is_sw) nxt = EXEC;
                else if (is_beq || is_bne)          nxt = BRANCH;
                else if (is_j || is_jal)            nxt = JUMP;
                else begin
                    illegal = 1'b1;
                    nxt     = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                if (is_r) begin
                    ALUSrcB = 2'd0;
                    ALUOp   = r_op;
                end else begin
                    ALUSrcB = 2'd2;
                    EXTOp   = ~is_zext;
                    ALUOp   = (is_lw || is_sw) ? ALU_ADDU : i_op;
                end
                nxt = (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ready) nxt = is_lw ? WB : FETCH;
            end
            WB: begin
                RegWrite = ~ovf_q;
                ovf_trap = ovf_q;
                RegDst   = is_r ? 2'd1 : 2'd0;
                WDSel    = is_lw ? 2'd1 : 2'd0;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_SUBU;
                PCWrite = is_beq ? Zero : ~Zero;
                NPCOp   = 2'd1;
                nxt     = FETCH;
            end
            JUMP: begin
                PCWrite = 1'b1;
                NPCOp   = 2'd2;
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    WDSel    = 2'd2;
                end
                nxt = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // Reset masks every strobe so an abandoned instruction writes nothing
        if (rst) begin
            nxt      = FETCH;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 2'd0;
            WDSel    = 2'd0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'd0;
            EXTOp    = 1'b0;
            NPCOp    = 2'd0;
            ALUOp    = ALU_NOP;
            illegal  = 1'b0;
            ovf_trap = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st <= FETCH;
        else     st <= nxt;
    end

    assign state = rst ? FETCH : st;

`ifdef OVERFLOW_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)                        ovf_q <= 1'b0;
        else if (st == EXEC && ovf_cand) ovf_q <= Overflow;
        else if (nxt == FETCH)          ovf_q <= 1'b0;
    end
`else
    logic unused_ovf;
    assign unused_ovf = Overflow ^ ovf_cand;
    assign ovf_q      = 1'b0;
`endif

endmodule
